// File: rtl/uart_fifo_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM state encodings and the
// oversampling ratio used by both the transmitter and the receiver.
package uart_fifo_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Oversample ticks per bit period
    localparam int OVERSAMPLE = 16;

    // Larger of two integers, used to size the tick counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_fifo_tx_baud_tick_gen.sv
// Oversample tick generator: divides clk by DVSR and raises s_tick on the
// last cycle of each division period. Shared with the UART receiver.
module baud_tick_gen #(
    parameter int DVSR   = 163,
    parameter int DVSR_W = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic s_tick
);

    logic [DVSR_W-1:0] div_cnt_r;

    // Divisor counter: cleared on request, wraps at DVSR-1 while enabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r <= {DVSR_W{1'b0}};
        end else if (clr) begin
            div_cnt_r <= {DVSR_W{1'b0}};
        end else if (en) begin
            if (div_cnt_r == DVSR_W'(DVSR - 1)) begin
                div_cnt_r <= {DVSR_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DVSR_W'(1);
            end
        end
    end

    // Tick is decoded from the registered count so it lands on the wrap cycle
    always_comb begin
        s_tick = 1'b0;
        if (en && (div_cnt_r == DVSR_W'(DVSR - 1))) begin
            s_tick = 1'b1;
        end else begin
            s_tick = 1'b0;
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter draining a first-word-fall-through TX FIFO, 8N1 LSB first.
// Optional even parity bit is enabled with `define UART_TX_PARITY_EN.
module uart_fifo_tx
    import uart_fifo_tx_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int DVSR_W  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_rdata,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done
);

    localparam int S_W = $clog2(max_int(SB_TICK, OVERSAMPLE));
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    uart_state_e     state_r;
    logic [DBIT-1:0] shift_r;
    logic [S_W-1:0]  s_cnt_r;
    logic [N_W-1:0]  n_cnt_r;
    logic            tx_r;
    logic            tx_busy_r;
    logic            tx_done_r;
    logic            pop_s;
    logic            tick_en_s;
    logic            tick_s;
`ifdef UART_TX_PARITY_EN
    logic            parity_r;

    // Even parity over one data word
    function automatic logic even_parity(input logic [DBIT-1:0] d);
        return ^d;
    endfunction
`endif

    // Pop strobe must be combinational so the FWFT FIFO advances in the same
    // cycle the head word is latched; held low while reset is asserted
    always_comb begin
        pop_s     = 1'b0;
        tick_en_s = 1'b0;
        if (reset_n && (state_r == ST_IDLE) && !fifo_empty) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (state_r != ST_IDLE) begin
            tick_en_s = 1'b1;
        end else begin
            tick_en_s = 1'b0;
        end
    end

    baud_tick_gen #(
        .DVSR   (DVSR),
        .DVSR_W (DVSR_W)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (pop_s),
        .en      (tick_en_s),
        .s_tick  (tick_s)
    );

    // Transmit FSM: sequences start, data, optional parity and stop bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= {DBIT{1'b0}};
            s_cnt_r   <= {S_W{1'b0}};
            n_cnt_r   <= {N_W{1'b0}};
            tx_r      <= 1'b1;
            tx_busy_r <= 1'b0;
            tx_done_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            tx_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tx_r      <= 1'b1;
                    tx_busy_r <= 1'b0;
                    if (pop_s) begin
                        shift_r   <= fifo_rdata;
                        s_cnt_r   <= {S_W{1'b0}};
                        n_cnt_r   <= {N_W{1'b0}};
                        tx_r      <= 1'b0;
                        tx_busy_r <= 1'b1;
                        state_r   <= ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_r  <= even_parity(fifo_rdata);
`endif
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (s_cnt_r == S_W'(OVERSAMPLE - 1)) begin
                            s_cnt_r <= {S_W{1'b0}};
                            n_cnt_r <= {N_W{1'b0}};
                            tx_r    <= shift_r[0];
                            state_r <= ST_DATA;
                        end else begin
                            s_cnt_r <= s_cnt_r + S_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (s_cnt_r == S_W'(OVERSAMPLE - 1)) begin
                            s_cnt_r <= {S_W{1'b0}};
                            shift_r <= shift_r >> 1;
                            if (n_cnt_r == N_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                                tx_r    <= parity_r;
                                state_r <= ST_PARITY;
`else
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
`endif
                            end else begin
                                n_cnt_r <= n_cnt_r + N_W'(1);
                                tx_r    <= shift_r[1];
                            end
                        end else begin
                            s_cnt_r <= s_cnt_r + S_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick_s) begin
                        if (s_cnt_r == S_W'(OVERSAMPLE - 1)) begin
                            s_cnt_r <= {S_W{1'b0}};
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            s_cnt_r <= s_cnt_r + S_W'(1);
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_s) begin
                        if (s_cnt_r == S_W'(SB_TICK - 1)) begin
                            s_cnt_r   <= {S_W{1'b0}};
                            tx_done_r <= 1'b1;
                            tx_busy_r <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            s_cnt_r <= s_cnt_r + S_W'(1);
                        end
                    end
                end
                default: begin
                    tx_r      <= 1'b1;
                    tx_busy_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd = pop_s;
    assign tx      = tx_r;
    assign tx_busy = tx_busy_r;
    assign tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Self-checking bench for uart_fifo_tx with DVSR=2, SB_TICK=16 (32 clk per bit).
module tb_uart_fifo_tx;

    localparam int BIT_CLK = 32;
`ifdef UART_TX_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif
    localparam int FRAME_CLK = FBITS * BIT_CLK;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_rd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rd_cnt = 0;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic       mask = 1'b0;

    uart_fifo_tx #(
        .DBIT    (8),
        .SB_TICK (16),
        .DVSR    (2),
        .DVSR_W  (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task refresh();
        fifo_empty = mask || (src_q.size() == 0);
        fifo_rdata = (src_q.size() > 0) ? src_q[0] : 8'h00;
    endtask

    // FIFO model: pop on the strobe, present the new head shortly after the edge
    always @(posedge clk) begin
        if (fifo_rd === 1'b1) begin
            rd_cnt++;
            if (src_q.size() > 0) void'(src_q.pop_front());
        end
        #1 refresh();
    end

    task push_word(input logic [7:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        refresh();
    endtask

    // Receive one frame; checks start, stop and tx_done timing inline
    task automatic rx_frame(output logic [7:0] d, output logic par, output int t_fall, output bit ok);
        int n = 0;
        ok = 1'b0; d = 8'h00; par = 1'b0; t_fall = 0;
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            $display("FAIL rx_start_timeout tx=%b required 0 within 2000 clk", tx);
            errors++;
            return;
        end
        t_fall = cyc;
        repeat (16) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            $display("FAIL start_bit tx=%b required 0", tx);
            errors++;
        end
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLK) @(negedge clk);
            d[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (BIT_CLK) @(negedge clk);
        par = tx;
`endif
        repeat (BIT_CLK) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            $display("FAIL stop_bit tx=%b required 1", tx);
            errors++;
        end
        repeat (15) @(negedge clk);
        checks++;
        if (tx_done !== 1'b0 || tx_busy !== 1'b1) begin
            $display("FAIL done_early done=%b busy=%b required done=0 busy=1", tx_done, tx_busy);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1 || (cyc - t_fall) !== FRAME_CLK) begin
            $display("FAIL done_pulse done=%b busy=%b tx=%b dt=%0d required 1 0 1 %0d",
                     tx_done, tx_busy, tx, cyc - t_fall, FRAME_CLK);
            errors++;
        end
        ok = 1'b1;
    endtask

    task automatic score(input logic [7:0] d, input string name);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s got=%02h required none", name, d);
            errors++;
        end else begin
            e = exp_q.pop_front();
            if (d !== e) begin
                $display("FAIL %s got=%02h required %02h", name, d, e);
                errors++;
            end
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || fifo_rd !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            $display("FAIL reset_vals tx=%b rd=%b busy=%b done=%b required 1 0 0 0", tx, fifo_rd, tx_busy, tx_done);
            errors++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd !== 1'b0 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || rd_cnt != 0) begin
            $display("FAIL idle_empty bad_cycles=%0d pops=%0d required 0 0", bad, rd_cnt);
            errors++;
        end
    endtask

    task automatic test_single();
        logic [7:0] d; logic p; int tf; bit ok; int c0; int r0;
        @(negedge clk);
        r0 = rd_cnt;
        c0 = cyc;
        push_word(8'hA5);
        #1;
        checks++;
        if (fifo_rd !== 1'b1) begin
            $display("FAIL pop_strobe rd=%b required 1", fifo_rd);
            errors++;
        end
        rx_frame(d, p, tf, ok);
        if (ok) begin
            score(d, "single_a5");
            checks++;
            if (tf !== c0 + 1) begin
                $display("FAIL start_latency fall=%0d required %0d", tf, c0 + 1);
                errors++;
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rd_cnt - r0 !== 1) begin
            $display("FAIL single_pops got=%0d required 1", rd_cnt - r0);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; logic p; int tf[3]; bit ok; int r0;
        @(negedge clk);
        r0 = rd_cnt;
        push_word(8'h00);
        push_word(8'hFF);
        push_word(8'h3C);
        for (int i = 0; i < 3; i++) begin
            rx_frame(d, p, tf[i], ok);
            if (ok) score(d, "b2b_data");
            if (ok && i > 0) begin
                checks++;
                if (tf[i] - tf[i-1] !== FRAME_CLK + 1) begin
                    $display("FAIL b2b_gap got=%0d required %0d", tf[i] - tf[i-1], FRAME_CLK + 1);
                    errors++;
                end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rd_cnt - r0 !== 3 || tx !== 1'b1 || tx_busy !== 1'b0) begin
            $display("FAIL b2b_end pops=%0d tx=%b busy=%b required 3 1 0", rd_cnt - r0, tx, tx_busy);
            errors++;
        end
    endtask

    task automatic test_empty_toggle();
        logic [7:0] d; logic p; int tf0; int tf1; bit ok; int r0; int bad = 0;
        @(negedge clk);
        r0 = rd_cnt;
        push_word(8'hC3);
        fork
            rx_frame(d, p, tf0, ok);
            begin
                repeat (60) @(negedge clk);
                mask = 1'b1;
                push_word(8'h96);
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (i % 5 == 0) mask = ~mask;
                    refresh();
                    #1;
                    if (fifo_rd !== 1'b0) bad++;
                end
                mask = 1'b0;
                refresh();
            end
        join
        if (ok) score(d, "toggle_first");
        checks++;
        if (bad != 0 || rd_cnt - r0 !== 1) begin
            $display("FAIL toggle_no_pop bad=%0d pops=%0d required 0 1", bad, rd_cnt - r0);
            errors++;
        end
        rx_frame(d, p, tf1, ok);
        if (ok) begin
            score(d, "toggle_second");
            checks++;
            if (tf1 - tf0 !== FRAME_CLK + 1) begin
                $display("FAIL toggle_gap got=%0d required %0d", tf1 - tf0, FRAME_CLK + 1);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0; int bad = 0; int r0;
        @(negedge clk);
        push_word(8'h55);
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            $display("FAIL mid_start_timeout tx=%b required 0", tx);
            errors++;
        end
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_rd !== 1'b0) begin
            $display("FAIL mid_reset tx=%b busy=%b rd=%b required 1 0 0", tx, tx_busy, fifo_rd);
            errors++;
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        r0 = rd_cnt;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || rd_cnt !== r0) begin
            $display("FAIL post_reset_idle bad=%0d pops=%0d required 0 0", bad, rd_cnt - r0);
            errors++;
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d; logic p; int tf; bit ok;
        @(negedge clk);
        push_word(8'h07);
        rx_frame(d, p, tf, ok);
        if (ok) begin
            score(d, "parity_07_data");
            checks++;
            if (p !== 1'b1) begin
                $display("FAIL parity_07 got=%b required 1", p);
                errors++;
            end
        end
        repeat (3) @(negedge clk);
        push_word(8'h03);
        rx_frame(d, p, tf, ok);
        if (ok) begin
            score(d, "parity_03_data");
            checks++;
            if (p !== 1'b0) begin
                $display("FAIL parity_03 got=%b required 0", p);
                errors++;
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_empty_toggle();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_leftover got=%0d required 0", exp_q.size());
            errors++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
